// File: rtl/background_layer_mux_pkg.sv
// Shared constants and types for the background layer mux.
package bg_mux_pkg;

  localparam int LAYER_BOOM = 0;
  localparam int LAYER_ICE  = 1;

  localparam logic [7:0] TRANSPARENT_RGB = 8'hFF;

  typedef enum logic [1:0] {
    OFF,
    HOLD,
    ON
  } layer_state_t;

endpackage

// File: rtl/background_layer_mux_if.sv
// Pixel/enable bus between the background generators and the layer mux.
interface background_layer_mux_if #(
  parameter int NUM_LAYERS = 3,
  parameter int RGB_W      = 8
);
  logic                          startOfFrame;
  logic [RGB_W-1:0]              BasicBackgroundRGB;
  logic [NUM_LAYERS*RGB_W-1:0]   layerRGB;
  logic [NUM_LAYERS-1:0]         layerDrawingRequest;
  logic [NUM_LAYERS-1:0]         layerEnableReq;
  logic [RGB_W-1:0]              backGroundRGB;
  logic [$clog2(NUM_LAYERS+1)-1:0] activeLayer;
  logic [NUM_LAYERS-1:0]         layerEnabled;

  modport master (
    output startOfFrame, BasicBackgroundRGB, layerRGB, layerDrawingRequest, layerEnableReq,
    input  backGroundRGB, activeLayer, layerEnabled
  );

  modport slave (
    input  startOfFrame, BasicBackgroundRGB, layerRGB, layerDrawingRequest, layerEnableReq,
    output backGroundRGB, activeLayer, layerEnabled
  );
endinterface

// File: rtl/bg_layer_gate.sv
// Frame-synchronised enable for one layer; minimum on-time counter built only
// when BG_MUX_HOLD_EN is defined.
//   state | meaning
//   OFF   | layer disabled
//   HOLD  | enabled, minimum on-time still running (cnt > 0)
//   ON    | enabled, follows the request at each frame start
module bg_layer_gate
  import bg_mux_pkg::*;
`ifdef BG_MUX_HOLD_EN
#(
  parameter int HOLD_FRAMES = 4
)
`endif
(
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic req,
  output logic en
);

  layer_state_t state;

`ifdef BG_MUX_HOLD_EN
  localparam int CNT_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD = (HOLD_FRAMES > 1) ? CNT_W'(HOLD_FRAMES - 1) : '0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= OFF;
      cnt   <= '0;
    end else if (sof) begin
      case (state)
        OFF: if (req) begin
          cnt   <= LOAD;
          state <= (LOAD != '0) ? HOLD : ON;
        end
        HOLD: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ON;
        end
        ON:      if (!req) state <= OFF;
        default: state <= OFF;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)  state <= OFF;
    else if (sof) state <= req ? ON : OFF;
  end
`endif

  assign en = (state != OFF);

endmodule

// File: rtl/background_layer_mux.sv
// Registered priority selector of effect layers over the basic background.
// Optional per-layer minimum on-time: define BG_MUX_HOLD_EN.
module background_layer_mux
  import bg_mux_pkg::*;
#(
  parameter int               NUM_LAYERS  = 3,
  parameter int               RGB_W       = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = RGB_W'(TRANSPARENT_RGB),
  parameter int               HOLD_FRAMES = 4
) (
  input logic                   clk,
  input logic                   resetN,
  background_layer_mux_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_LAYERS + 1);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || HOLD_FRAMES < 0 || HOLD_FRAMES > 255) begin : g_bad_param
    $error("background_layer_mux: NUM_LAYERS or HOLD_FRAMES out of range");
  end

  logic [NUM_LAYERS-1:0] en_q;
  logic [NUM_LAYERS-1:0] cand;
  logic [RGB_W-1:0]      sel_rgb;
  logic [IDX_W-1:0]      sel_idx;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
`ifdef BG_MUX_HOLD_EN
    bg_layer_gate #(.HOLD_FRAMES(HOLD_FRAMES)) u_gate (
`else
    bg_layer_gate u_gate (
`endif
      .clk    (clk),
      .resetN (resetN),
      .sof    (bus.startOfFrame),
      .req    (bus.layerEnableReq[g]),
      .en     (en_q[g])
    );
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      cand[i] = en_q[i] & bus.layerDrawingRequest[i]
              & (bus.layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
  end

  // Scan from lowest priority up so the lowest-index candidate wins.
  always_comb begin
    sel_rgb = bus.BasicBackgroundRGB;
    sel_idx = IDX_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_rgb = bus.layerRGB[i*RGB_W +: RGB_W];
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.backGroundRGB <= '0;
      bus.activeLayer   <= '0;
    end else begin
      bus.backGroundRGB <= sel_rgb;
      bus.activeLayer   <= sel_idx;
    end
  end

  assign bus.layerEnabled = en_q;

endmodule

// File: tb/tb_background_layer_mux.sv
// Directed self-checking bench for background_layer_mux (NUM_LAYERS=3, HOLD_FRAMES=4).
module tb_background_layer_mux;
  import bg_mux_pkg::*;

`ifdef BG_MUX_HOLD_EN
  localparam int HOLD_LEN = 4;
`else
  localparam int HOLD_LEN = 1;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  background_layer_mux_if #(.NUM_LAYERS(3), .RGB_W(8)) bus ();

  background_layer_mux #(
    .NUM_LAYERS (3),
    .RGB_W      (8),
    .TRANSPARENT(8'hFF),
    .HOLD_FRAMES(4)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0]  draw;
    logic [23:0] rgb;
    logic [7:0]  basic;
    logic [7:0]  exp_rgb;
    logic [1:0]  exp_idx;
  } vec_t;

  vec_t vecs[9];
  int vec_count  = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  // Single-frame request on layer 0; returns how many frames it stayed enabled.
  task automatic hold_run(input bit glitch, output int frames);
    frames = 0;
    bus.layerEnableReq[LAYER_BOOM] = 1'b1;
    pulse_sof();
    bus.layerEnableReq[LAYER_BOOM] = 1'b0;
    tick();
    for (int f = 0; f < 12 && bus.layerEnabled[LAYER_BOOM]; f++) begin
      frames++;
      if (glitch && f == 1) begin
        bus.layerEnableReq[LAYER_BOOM] = 1'b1;
        tick();
        bus.layerEnableReq[LAYER_BOOM] = 1'b0;
      end
      tick();
      pulse_sof();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames;
    logic [7:0] basic;

    vecs[0] = '{3'b111, {8'h33, 8'h22, 8'h11}, 8'h05, 8'h11, 2'd0};
    vecs[1] = '{3'b110, {8'h33, 8'h22, 8'h11}, 8'h05, 8'h22, 2'd1};
    vecs[2] = '{3'b111, {8'h33, 8'h22, 8'hFF}, 8'h05, 8'h22, 2'd1};
    vecs[3] = '{3'b111, {8'hFF, 8'hFF, 8'hFF}, 8'h05, 8'h05, 2'd3};
    vecs[4] = '{3'b000, {8'h33, 8'h22, 8'h11}, 8'h07, 8'h07, 2'd3};
    vecs[5] = '{3'b100, {8'h33, 8'h22, 8'h11}, 8'h07, 8'h33, 2'd2};
    vecs[6] = '{3'b101, {8'h33, 8'h22, 8'hFF}, 8'h07, 8'h33, 2'd2};
    vecs[7] = '{3'b000, {8'h33, 8'h22, 8'h11}, 8'hFF, 8'hFF, 2'd3};
    vecs[8] = '{3'b011, {8'h33, 8'hFF, 8'h11}, 8'h07, 8'h11, 2'd0};

    // Reset with random inputs, including frame pulses
    for (int c = 0; c < 4; c++) begin
      bus.startOfFrame        = 1'($urandom_range(0, 1));
      bus.BasicBackgroundRGB  = 8'($urandom);
      bus.layerRGB            = 24'($urandom);
      bus.layerDrawingRequest = 3'($urandom);
      bus.layerEnableReq      = 3'b111;
      tick();
      check("reset_rgb", 32'(bus.backGroundRGB), 32'h0);
      check("reset_idx", 32'(bus.activeLayer), 32'h0);
      check("reset_en",  32'(bus.layerEnabled), 32'h0);
    end
    bus.startOfFrame = 1'b0;
    @(negedge clk);
    resetN = 1'b1;

    // Layers stay off until the first frame start
    for (int c = 0; c < 4; c++) begin
      basic = 8'($urandom);
      bus.BasicBackgroundRGB  = basic;
      bus.layerRGB            = 24'($urandom);
      bus.layerDrawingRequest = 3'b111;
      bus.layerEnableReq      = 3'($urandom);
      tick();
      check("post_reset_en",  32'(bus.layerEnabled), 32'h0);
      check("post_reset_idx", 32'(bus.activeLayer), 32'd3);
      check("post_reset_rgb", 32'(bus.backGroundRGB), 32'(basic));
    end

    bus.layerEnableReq      = 3'b000;
    bus.layerDrawingRequest = 3'b000;
    bus.BasicBackgroundRGB  = 8'h05;
    bus.layerRGB            = {8'h33, 8'h22, 8'h11};
    tick();

    // Minimum on-time, with a request glitch inside the hold window
    hold_run(1'b1, frames);
    check("hold_frames", 32'(frames), 32'(HOLD_LEN));
    check("hold_end_en", 32'(bus.layerEnabled), 32'h0);

    // Reset in the middle of a hold
    bus.layerEnableReq[LAYER_BOOM] = 1'b1;
    pulse_sof();
    bus.layerEnableReq[LAYER_BOOM] = 1'b0;
    check("midhold_on", 32'(bus.layerEnabled), 32'b001);
    tick();
    pulse_sof();
    check("midhold_second", 32'(bus.layerEnabled), (HOLD_LEN > 1) ? 32'b001 : 32'b000);
    tick();
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("midhold_rst_en",  32'(bus.layerEnabled), 32'h0);
    check("midhold_rst_rgb", 32'(bus.backGroundRGB), 32'h0);
    tick();
    @(negedge clk);
    resetN = 1'b1;
    tick();
    check("midhold_rel_en", 32'(bus.layerEnabled), 32'h0);
    hold_run(1'b0, frames);
    check("midhold_rerun_frames", 32'(frames), 32'(HOLD_LEN));

    // Frame sync on layer 1 (Ice)
    bus.layerDrawingRequest = 3'b010;
    bus.layerRGB            = {8'h33, 8'h22, 8'h11};
    bus.BasicBackgroundRGB  = 8'h05;
    tick();
    bus.layerEnableReq[LAYER_ICE] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("sync_mid_en",  32'(bus.layerEnabled), 32'h0);
      check("sync_mid_rgb", 32'(bus.backGroundRGB), 32'h05);
    end
    pulse_sof();
    check("sync_sof_en",  32'(bus.layerEnabled), 32'b010);
    check("sync_sof_rgb", 32'(bus.backGroundRGB), 32'h05);
    check("sync_sof_idx", 32'(bus.activeLayer), 32'd3);
    tick();
    check("sync_next_rgb", 32'(bus.backGroundRGB), 32'h22);
    check("sync_next_idx", 32'(bus.activeLayer), 32'd1);

    // Enable everything, then run the priority/transparency table
    bus.layerEnableReq = 3'b111;
    pulse_sof();
    check("table_en", 32'(bus.layerEnabled), 32'b111);
    for (int v = 0; v < 9; v++) begin
      bus.layerDrawingRequest = vecs[v].draw;
      bus.layerRGB            = vecs[v].rgb;
      bus.BasicBackgroundRGB  = vecs[v].basic;
      tick();
      check($sformatf("vec%0d_rgb", v), 32'(bus.backGroundRGB), 32'(vecs[v].exp_rgb));
      check($sformatf("vec%0d_idx", v), 32'(bus.activeLayer), 32'(vecs[v].exp_idx));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
